// File: rtl/mcore_pkg.sv
// Shared MADAM core constants: bit reader register map, op codes and FSM states.
package mcore_pkg;

    localparam int unsigned BITRD_OFF_W = 5;
    localparam int unsigned BITRD_CNT_W = 8;

    localparam logic [31:0] M_UTIL_ADDR      = 32'h0000_1000;
    localparam logic [31:0] BITRD_STATUS_OFS = 32'h0000_0000;
    localparam logic [31:0] BITRD_BASE_OFS   = 32'h0000_0004;
    localparam logic [31:0] BITRD_CMD_OFS    = 32'h0000_0008;
    localparam logic [31:0] BITRD_DATA_OFS   = 32'h0000_000C;

    localparam logic [7:0] BITRD_SKIP     = 8'd1;
    localparam logic [7:0] BITRD_READ     = 8'd2;
    localparam logic [7:0] BITRD_MAX_READ = 8'd32;

    typedef enum logic [1:0] {
        BITRD_IDLE       = 2'd0,
        BITRD_FETCH_REQ  = 2'd1,
        BITRD_FETCH_WAIT = 2'd2,
        BITRD_SHIFT      = 2'd3
    } bitrd_state_e;

    // A READ never returns more than one word's worth of bits.
    function automatic logic [7:0] bitrd_clamp_read(input logic [7:0] n);
        return (n > BITRD_MAX_READ) ? BITRD_MAX_READ : n;
    endfunction

endpackage

// File: rtl/madam_bit_reader_regs.sv
// Bit reader register port: address decode, registered read data, write strobes.
module madam_bit_reader_regs
    import mcore_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 32
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    input  logic [ADDR_WIDTH-1:0] addra_i,
    input  logic                  ena_i,
    input  logic [3:0]            wea_i,
    input  logic                  busy_i,
    input  logic                  status_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    output logic [DATA_WIDTH-1:0] douta_o,
    output logic                  base_wr_c,
    output logic                  cmd_wr_c
);

    localparam logic [ADDR_WIDTH-1:0] STATUS_ADDR = ADDR_WIDTH'(M_UTIL_ADDR + BITRD_STATUS_OFS);
    localparam logic [ADDR_WIDTH-1:0] BASE_ADDR   = ADDR_WIDTH'(M_UTIL_ADDR + BITRD_BASE_OFS);
    localparam logic [ADDR_WIDTH-1:0] CMD_ADDR    = ADDR_WIDTH'(M_UTIL_ADDR + BITRD_CMD_OFS);
    localparam logic [ADDR_WIDTH-1:0] DATA_ADDR   = ADDR_WIDTH'(M_UTIL_ADDR + BITRD_DATA_OFS);

    logic                  wr_c;
    logic                  rd_c;
    logic [DATA_WIDTH-1:0] rdata_c;
    logic [DATA_WIDTH-1:0] douta_q;

    assign wr_c      = ena_i && (wea_i != 4'b0000);
    assign rd_c      = ena_i && (wea_i == 4'b0000);
    assign base_wr_c = wr_c && (addra_i == BASE_ADDR);
    assign cmd_wr_c  = wr_c && (addra_i == CMD_ADDR);

    // Read mux; unmapped addresses return zero.
    always_comb begin
        rdata_c = '0;
        if (addra_i == STATUS_ADDR) begin
            rdata_c = DATA_WIDTH'(status_i);
        end else if (addra_i == CMD_ADDR) begin
            rdata_c = DATA_WIDTH'(busy_i);
        end else if (addra_i == DATA_ADDR) begin
            rdata_c = data_i;
        end
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            douta_q <= '0;
        end else if (rd_c) begin
            douta_q <= rdata_c;
        end
    end

    assign douta_o = douta_q;

endmodule

// File: rtl/madam_bit_reader.sv
// Memory-backed MSB-first bitstream reader with a BRAM-style register port.
// Build option: define BITRD_ERR_EN to latch mem_rsp_error into STATUS[0] and zero errored words.
module madam_bit_reader
    import mcore_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 32
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    input  logic [ADDR_WIDTH-1:0] addra,
    input  logic [DATA_WIDTH-1:0] dina,
    output logic [DATA_WIDTH-1:0] douta,
    input  logic                  ena,
    input  logic [3:0]            wea,
    output logic                  mem_req,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_we,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic [3:0]            mem_be,
    input  logic                  mem_gnt,
    input  logic                  mem_rsp_valid,
    input  logic [DATA_WIDTH-1:0] mem_rsp_rdata,
    input  logic                  mem_rsp_error
);

    bitrd_state_e             state_q, state_d;
    logic [ADDR_WIDTH-1:0]    ptr_q, ptr_d;
    logic [BITRD_OFF_W-1:0]   off_q, off_d;
    logic                     valid_q, valid_d;
    logic [DATA_WIDTH-1:0]    word_q, word_d;
    logic [BITRD_CNT_W-1:0]   cnt_q, cnt_d;
    logic                     rd_q, rd_d;
    logic [DATA_WIDTH-1:0]    data_q, data_d;
    logic                     status_q, status_d;
    logic                     req_q, req_d;
    logic                     busy_q, busy_d;

    logic                     base_wr_c;
    logic                     cmd_wr_c;
    logic [7:0]               op_c;
    logic [7:0]               n_c;

    assign op_c = dina[7:0];
    assign n_c  = dina[15:8];

    madam_bit_reader_regs #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_regs (
        .aclk      (aclk),
        .aresetn   (aresetn),
        .addra_i   (addra),
        .ena_i     (ena),
        .wea_i     (wea),
        .busy_i    (busy_q),
        .status_i  (status_q),
        .data_i    (data_q),
        .douta_o   (douta),
        .base_wr_c (base_wr_c),
        .cmd_wr_c  (cmd_wr_c)
    );

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state_q  <= BITRD_IDLE;
            ptr_q    <= '0;
            off_q    <= '0;
            valid_q  <= 1'b0;
            word_q   <= '0;
            cnt_q    <= '0;
            rd_q     <= 1'b0;
            data_q   <= '0;
            status_q <= 1'b0;
            req_q    <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            off_q    <= off_d;
            valid_q  <= valid_d;
            word_q   <= word_d;
            cnt_q    <= cnt_d;
            rd_q     <= rd_d;
            data_q   <= data_d;
            status_q <= status_d;
            req_q    <= req_d;
            busy_q   <= busy_d;
        end
    end

    // Command accept, lazy word fetch and one-bit-per-cycle consumption.
    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        off_d    = off_q;
        valid_d  = valid_q;
        word_d   = word_q;
        cnt_d    = cnt_q;
        rd_d     = rd_q;
        data_d   = data_q;
        status_d = status_q;

        case (state_q)
            BITRD_IDLE: begin
                if (base_wr_c) begin
                    ptr_d    = ADDR_WIDTH'(dina & ~DATA_WIDTH'(3));
                    off_d    = '0;
                    valid_d  = 1'b0;
                    cnt_d    = '0;
                    status_d = 1'b0;
                    state_d  = BITRD_FETCH_REQ;
                end else if (cmd_wr_c) begin
                    if (op_c == BITRD_READ) begin
                        data_d = '0;
                        rd_d   = 1'b1;
                        cnt_d  = bitrd_clamp_read(n_c);
                    end else if (op_c == BITRD_SKIP) begin
                        rd_d  = 1'b0;
                        cnt_d = n_c;
                    end
                    if (((op_c == BITRD_READ) || (op_c == BITRD_SKIP)) && (cnt_d != '0)) begin
                        state_d = valid_q ? BITRD_SHIFT : BITRD_FETCH_REQ;
                    end
                end
            end
            BITRD_FETCH_REQ: begin
                if (mem_gnt) begin
                    state_d = BITRD_FETCH_WAIT;
                end
            end
            BITRD_FETCH_WAIT: begin
                if (mem_rsp_valid) begin
`ifdef BITRD_ERR_EN
                    word_d   = mem_rsp_error ? '0 : mem_rsp_rdata;
                    status_d = status_q | mem_rsp_error;
`else
                    word_d   = mem_rsp_rdata;
`endif
                    ptr_d    = ptr_q + ADDR_WIDTH'(4);
                    off_d    = '0;
                    valid_d  = 1'b1;
                    state_d  = (cnt_q == '0) ? BITRD_IDLE : BITRD_SHIFT;
                end
            end
            BITRD_SHIFT: begin
                word_d = {word_q[DATA_WIDTH-2:0], 1'b0};
                off_d  = off_q + BITRD_OFF_W'(1);
                cnt_d  = cnt_q - BITRD_CNT_W'(1);
                if (rd_q) begin
                    data_d = {data_q[DATA_WIDTH-2:0], word_q[DATA_WIDTH-1]};
                end
                if (off_q == BITRD_OFF_W'(31)) begin
                    valid_d = 1'b0;
                end
                // Finishing exactly on a word boundary leaves the next fetch for the next command.
                if (cnt_q == BITRD_CNT_W'(1)) begin
                    state_d = BITRD_IDLE;
                end else if (off_q == BITRD_OFF_W'(31)) begin
                    state_d = BITRD_FETCH_REQ;
                end
            end
            default: begin
                state_d = BITRD_IDLE;
            end
        endcase

        req_d  = (state_d == BITRD_FETCH_REQ);
        busy_d = (state_d != BITRD_IDLE);
    end

`ifndef BITRD_ERR_EN
    logic unused_err_c;
    assign unused_err_c = mem_rsp_error;
`endif

    assign mem_req   = req_q;
    assign mem_addr  = ptr_q;
    assign mem_we    = 1'b0;
    assign mem_wdata = '0;
    assign mem_be    = 4'hF;

endmodule

// File: tb/tb_madam_bit_reader.sv
// Self-checking bench for madam_bit_reader: directed plan plus random commands vs a bit-position model.
module tb_madam_bit_reader;
    import mcore_pkg::*;

    localparam logic [31:0] A_STATUS = M_UTIL_ADDR + BITRD_STATUS_OFS;
    localparam logic [31:0] A_BASE   = M_UTIL_ADDR + BITRD_BASE_OFS;
    localparam logic [31:0] A_CMD    = M_UTIL_ADDR + BITRD_CMD_OFS;
    localparam logic [31:0] A_DATA   = M_UTIL_ADDR + BITRD_DATA_OFS;

    logic        aclk;
    logic        aresetn;
    logic [31:0] addra, dina, douta;
    logic        ena;
    logic [3:0]  wea;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_we;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_gnt, mem_rsp_valid, mem_rsp_error;
    logic [31:0] mem_rsp_rdata;

    int          checks;
    int          failures;
    logic        stall, err_inject, spur;
    logic        rsp_v_q, rsp_e_q;
    logic [31:0] rsp_d_q;
    logic [31:0] salt;
    logic [31:0] obs_fetch[$];
    logic [31:0] exp_fetch[$];
    logic [31:0] last_data;

    // Reference model: stream base, absolute bit position, word index currently held.
    logic [31:0] m_base;
    int          m_pos;
    int          m_loaded;
    logic [31:0] m_data;

    madam_bit_reader #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) dut (
        .aclk          (aclk),
        .aresetn       (aresetn),
        .addra         (addra),
        .dina          (dina),
        .douta         (douta),
        .ena           (ena),
        .wea           (wea),
        .mem_req       (mem_req),
        .mem_addr      (mem_addr),
        .mem_we        (mem_we),
        .mem_wdata     (mem_wdata),
        .mem_be        (mem_be),
        .mem_gnt       (mem_gnt),
        .mem_rsp_valid (mem_rsp_valid),
        .mem_rsp_rdata (mem_rsp_rdata),
        .mem_rsp_error (mem_rsp_error)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'h0027_1BD0: return 32'hD72B_2ED6;
            32'h0027_1BD4: return 32'hCD72_F74D;
            32'h0027_1BD8: return 32'h6ED6_5CB5;
            default:       return (a * 32'h9E37_79B1) ^ salt;
        endcase
    endfunction

    assign mem_gnt       = mem_req && !stall;
    assign mem_rsp_valid = rsp_v_q || spur;
    assign mem_rsp_rdata = rsp_d_q;
    assign mem_rsp_error = rsp_e_q;

    // Memory: immediate grant unless stalled, response one cycle after grant.
    always @(posedge aclk) begin
        if (!aresetn) begin
            rsp_v_q <= 1'b0;
            rsp_e_q <= 1'b0;
            rsp_d_q <= '0;
        end else begin
            rsp_v_q <= mem_req && mem_gnt;
            rsp_e_q <= mem_req && mem_gnt && err_inject;
            rsp_d_q <= mem_word(mem_addr);
            if (mem_req && mem_gnt) obs_fetch.push_back(mem_addr);
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    function automatic logic m_bit(input int p);
        logic [31:0] w;
        w = mem_word(m_base + 32'(4 * (p / 32)));
        return w[5'(31 - (p % 32))];
    endfunction

    task automatic m_consume(input int n, input bit rd);
        for (int i = 0; i < n; i++) begin
            int w;
            w = m_pos / 32;
            if (w != m_loaded) begin
                exp_fetch.push_back(m_base + 32'(4 * w));
                m_loaded = w;
            end
            if (rd) m_data = {m_data[30:0], m_bit(m_pos)};
            m_pos++;
        end
    endtask

    // Register tasks are entered and left on a falling edge.
    task automatic reg_write(input logic [31:0] a, input logic [31:0] d);
        ena = 1'b1; wea = 4'hF; addra = a; dina = d;
        @(negedge aclk);
        ena = 1'b0; wea = 4'h0;
    endtask

    task automatic reg_read(input logic [31:0] a, output logic [31:0] d);
        ena = 1'b1; wea = 4'h0; addra = a;
        @(negedge aclk);
        d = douta;
        ena = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        logic [31:0] b;
        int n;
        b = 32'd1;
        n = 0;
        while (b[0] && n < 600) begin
            reg_read(A_CMD, b);
            n++;
        end
        chk({tag, "_idle"}, b, 32'd0);
    endtask

    task automatic check_fetches(input string tag);
        chk({tag, "_nfetch"}, 32'(obs_fetch.size()), 32'(exp_fetch.size()));
        while (obs_fetch.size() > 0 && exp_fetch.size() > 0)
            chk({tag, "_fetch"}, obs_fetch.pop_front(), exp_fetch.pop_front());
        obs_fetch.delete();
        exp_fetch.delete();
    endtask

    task automatic do_base(input logic [31:0] a);
        logic [31:0] b;
        reg_write(A_BASE, a);
        m_base = a & ~32'd3;
        m_pos = 0;
        m_loaded = 0;
        exp_fetch.push_back(m_base);
        reg_read(A_CMD, b);
        chk("base_busy", b, 32'd1);
        wait_idle("base");
        check_fetches("base");
    endtask

    task automatic do_cmd(input logic [7:0] op, input logic [7:0] n, input string tag);
        logic [31:0] b, d;
        int eff;
        eff = 0;
        reg_write(A_CMD, {8'($urandom), 8'($urandom), n, op});
        if (op == BITRD_READ) begin
            eff = (n > 8'd32) ? 32 : int'(n);
            m_data = '0;
            m_consume(eff, 1'b1);
        end else if (op == BITRD_SKIP) begin
            eff = int'(n);
            m_consume(eff, 1'b0);
        end
        reg_read(A_CMD, b);
        chk({tag, "_busy"}, b, (eff != 0) ? 32'd1 : 32'd0);
        wait_idle(tag);
        reg_read(A_DATA, d);
        chk({tag, "_data"}, d, m_data);
        check_fetches(tag);
        last_data = d;
    endtask

    initial begin
        #900_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] r;
        salt = $urandom;
        checks = 0; failures = 0;
        aresetn = 1'b0; ena = 1'b0; wea = 4'h0; addra = '0; dina = '0;
        stall = 1'b0; err_inject = 1'b0; spur = 1'b0;
        m_base = '0; m_pos = 0; m_loaded = -1; m_data = '0; last_data = '0;
        repeat (3) @(negedge aclk);
        aresetn = 1'b1;

        chk("rst_douta", douta, 32'd0);
        chk("rst_req", 32'(mem_req), 32'd0);
        chk("rst_addr", mem_addr, 32'd0);
        chk("rst_be", 32'(mem_be), 32'hF);
        chk("rst_we", 32'(mem_we), 32'd0);
        chk("rst_wdata", mem_wdata, 32'd0);
        reg_read(A_CMD, r);    chk("rst_busy", r, 32'd0);
        reg_read(A_DATA, r);   chk("rst_data", r, 32'd0);
        reg_read(A_STATUS, r); chk("rst_status", r, 32'd0);
        reg_read(32'h0000_1010, r); chk("unmapped_rd", r, 32'd0);

        do_base(32'h0027_1BD0);
        do_cmd(BITRD_READ, 8'd6, "rd6a");  chk("plan_rd6a", last_data, 32'h35);
        do_cmd(BITRD_READ, 8'd6, "rd6b");  chk("plan_rd6b", last_data, 32'h32);
        do_cmd(BITRD_SKIP, 8'd60, "sk60");
        do_cmd(BITRD_READ, 8'd6, "rd6c");  chk("plan_rd6c", last_data, 32'h35);
        do_cmd(BITRD_READ, 8'd6, "rd6d");  chk("plan_rd6d", last_data, 32'h25);

        do_base(32'h0027_1BD0);
        do_cmd(BITRD_READ, 8'd32, "rd32"); chk("plan_rd32", last_data, 32'hD72B_2ED6);
        do_base(32'h0027_1BD0);
        do_cmd(BITRD_READ, 8'd40, "rd40"); chk("plan_rd40", last_data, 32'hD72B_2ED6);
        do_cmd(BITRD_READ, 8'd6, "rd6e");  chk("plan_rd6e", last_data, 32'h33);
        do_cmd(BITRD_READ, 8'd5, "rd5");
        do_cmd(8'h07, 8'd5, "noop");
        do_cmd(BITRD_READ, 8'd0, "rd0");   chk("plan_rd0", last_data, 32'd0);

        // Stalled grant: request held, busy, further writes ignored.
        stall = 1'b1;
        reg_write(A_BASE, 32'h0027_1BD6);
        for (int i = 0; i < 10; i++) begin
            chk("stall_req", 32'(mem_req), 32'd1);
            chk("stall_addr", mem_addr, 32'h0027_1BD4);
            @(negedge aclk);
        end
        reg_write(A_CMD, {16'h0, 8'd6, BITRD_READ});
        reg_write(A_BASE, 32'h0000_1234);
        reg_read(A_CMD, r); chk("stall_busy", r, 32'd1);
        chk("stall_addr2", mem_addr, 32'h0027_1BD4);
        stall = 1'b0;
        m_base = 32'h0027_1BD4; m_pos = 0; m_loaded = 0;
        exp_fetch.push_back(m_base);
        wait_idle("stall");
        check_fetches("stall");
        reg_read(A_DATA, r); chk("ignored_cmd_data", r, m_data);
        do_cmd(BITRD_READ, 8'd6, "rd_after_stall"); chk("plan_stall_rd", last_data, 32'h33);

        // Reset in the middle of a fetch.
        stall = 1'b1;
        reg_write(A_BASE, 32'h0027_1BD0);
        repeat (3) @(negedge aclk);
        chk("pre_rst_req", 32'(mem_req), 32'd1);
        aresetn = 1'b0;
        @(negedge aclk);
        aresetn = 1'b1;
        stall = 1'b0;
        chk("mid_rst_req", 32'(mem_req), 32'd0);
        chk("mid_rst_addr", mem_addr, 32'd0);
        chk("mid_rst_douta", douta, 32'd0);
        chk("mid_rst_be", 32'(mem_be), 32'hF);
        repeat (3) @(negedge aclk);
        chk("mid_rst_req2", 32'(mem_req), 32'd0);
        chk("mid_rst_nfetch", 32'(obs_fetch.size()), 32'd0);
        obs_fetch.delete();
        spur = 1'b1;
        @(negedge aclk);
        spur = 1'b0;
        reg_read(A_CMD, r);  chk("late_rsp_busy", r, 32'd0);
        reg_read(A_DATA, r); chk("late_rsp_data", r, 32'd0);
        chk("late_rsp_req", 32'(mem_req), 32'd0);
        m_data = '0;

        // Response error on the first word.
        err_inject = 1'b1;
        reg_write(A_BASE, 32'h0027_1BD0);
        wait_idle("err_base");
        err_inject = 1'b0;
        exp_fetch.push_back(32'h0027_1BD0);
        check_fetches("err_base");
        reg_read(A_STATUS, r);
`ifdef BITRD_ERR_EN
        chk("err_status", r, 32'd1);
`else
        chk("err_status", r, 32'd0);
`endif
        reg_write(A_CMD, {16'h0, 8'd6, BITRD_READ});
        wait_idle("err_rd");
        reg_read(A_DATA, r);
`ifdef BITRD_ERR_EN
        chk("err_rd6", r, 32'd0);
`else
        chk("err_rd6", r, 32'h35);
`endif
        m_data = r;
        do_base(32'h0027_1BD0);
        reg_read(A_STATUS, r); chk("err_cleared", r, 32'd0);

        // Random command mix against the model.
        for (int it = 0; it < 40; it++) begin
            int sel;
            sel = $urandom_range(0, 9);
            if (sel == 0) begin
                if ($urandom_range(0, 1) == 0) do_base(32'h0027_0000 + 32'($urandom_range(0, 16383)));
                else do_base($urandom);
            end else if (sel == 1) begin
                do_cmd(8'($urandom_range(3, 255)), 8'($urandom), "rnd_noop");
            end else if (sel <= 5) begin
                do_cmd(BITRD_READ, 8'($urandom_range(0, 40)), "rnd_read");
            end else begin
                do_cmd(BITRD_SKIP, 8'($urandom_range(0, 255)), "rnd_skip");
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
